ifetch_prefetch: RTL and testbench

IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

---
 rtl/ifetch_prefetch_pkg.sv | 20 ++
 rtl/ifetch_fifo.sv | 58 +++++
 rtl/ifetch_prefetch.sv | 160 ++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_prefetch_pkg.sv
// Shared types for the instruction prefetcher: FSM state encoding,
// the FIFO entry layout and the instruction size in bytes.
package ifetch_prefetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic        fault;
    logic [63:0] pc;
    logic [31:0] data;
  } fifo_entry_t;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned ENTRY_W    = $bits(fifo_entry_t);

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction FIFO: up to two pushes and one pop per cycle, synchronous
// flush that overrides push/pop, registered occupancy count and head
// outputs read straight from the storage register at the read pointer.
module ifetch_fifo
  import ifetch_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push0,
  input  logic [ENTRY_W-1:0]         entry0,
  input  logic                       push1,
  input  logic [ENTRY_W-1:0]         entry1,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       head_valid,
  output logic [ENTRY_W-1:0]         head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr_p1;
  logic [CW-1:0]      num_push;
  logic               pop_en;

  assign wr_ptr_p1  = wr_ptr + PW'(1);
  assign num_push   = CW'(push0) + CW'(push1);
  assign head_valid = (count != '0);
  assign pop_en     = pop && head_valid;
  assign head       = mem[rd_ptr];

  // Storage, pointers and occupancy; reset clears storage so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push0) mem[wr_ptr] <= entry0;
      if (push1) mem[wr_ptr_p1] <= entry1;
      wr_ptr <= wr_ptr + num_push[PW-1:0];
      if (pop_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count + num_push - CW'(pop_en);
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: fetches 64-bit words from a zero-latency RAM,
// splits them into 32-bit instructions and queues them for the consumer.
// Valid/ready: an entry transfers on a rising edge where inst_valid and
// inst_ready are both high; head outputs hold while valid && !ready.
// Optional macro IFETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0002_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [63:0] RAM_START  = 64'h0002_0000,
  parameter int unsigned RAM_SIZE   = 1072
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [63:0] HADDR,
  output logic        HWRITE,
  output logic [63:0] HWDATA,
  input  logic [63:0] HRDATA,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  output logic        inst_fault,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [63:0] RAM_LAST = RAM_START + 64'(RAM_SIZE) - 64'd8;

  fsm_state_t    state, state_nxt;
  logic [63:0]   fetch_pc, fetch_pc_nxt;
  logic [63:0]   fetch_addr;
  logic          is_fault;
  logic [CW-1:0] need;
  logic [CW-1:0] free;
  logic [CW-1:0] count;
  logic          can_issue;
  logic          push0, push1;
  fifo_entry_t   e0, e1, head;
  logic          head_valid;
  logic          fetch_issue;
  logic          fetch_stall;

  assign fetch_addr = {fetch_pc[63:3], 3'b000};
  assign is_fault   = (fetch_addr < RAM_START) || (fetch_addr > RAM_LAST) ||
                      (fetch_pc[1:0] != 2'b00);
  // A fault pushes one entry, as does an odd-word fetch; an even word pushes two.
  assign need       = (is_fault || fetch_pc[2]) ? CW'(1) : CW'(2);
  assign free       = CW'(FIFO_DEPTH) - count;
  assign can_issue  = (free >= need);

  assign HADDR      = fetch_addr;
  assign HWRITE     = 1'b0;
  assign HWDATA     = '0;
  assign dbg_state  = state;

  assign inst_valid = head_valid;
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;
  assign inst_fault = head.fault;

  // State and fetch PC registers.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // Next state, fetch PC advance and FIFO push requests; redirect wins.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push0        = 1'b0;
    push1        = 1'b0;
    e0           = '0;
    e1           = '0;
    fetch_issue  = 1'b0;
    fetch_stall  = 1'b0;
    if (redirect_valid) begin
      state_nxt    = FETCH;
      fetch_pc_nxt = redirect_pc;
    end else begin
      case (state)
        BOOT: state_nxt = FETCH;
        FETCH: begin
          if (!can_issue) begin
            fetch_stall = 1'b1;
          end else if (is_fault) begin
            push0     = 1'b1;
            e0.fault  = 1'b1;
            e0.pc     = fetch_pc;
            e0.data   = 32'h0;
            state_nxt = HALT;
          end else if (fetch_pc[2]) begin
            push0        = 1'b1;
            e0.pc        = fetch_pc;
            e0.data      = HRDATA[63:32];
            fetch_pc_nxt = fetch_pc + 64'(INST_BYTES);
            fetch_issue  = 1'b1;
          end else begin
            push0        = 1'b1;
            push1        = 1'b1;
            e0.pc        = fetch_pc;
            e0.data      = HRDATA[31:0];
            e1.pc        = fetch_pc + 64'(INST_BYTES);
            e1.data      = HRDATA[63:32];
            fetch_pc_nxt = fetch_pc + 64'(2 * INST_BYTES);
            fetch_issue  = 1'b1;
          end
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = BOOT;
      endcase
    end
  end

  ifetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (HCLK),
    .rst_n      (HRESET),
    .flush      (redirect_valid),
    .push0      (push0),
    .entry0     (e0),
    .push1      (push1),
    .entry1     (e1),
    .pop        (inst_ready),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

`ifdef IFETCH_PERF_CNT_EN
  // Saturating counters of issued fetches and space-blocked FETCH cycles.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch_issue && (perf_fetch_cnt != '1)) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (fetch_stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = fetch_issue ^ fetch_stall;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Testbench for ifetch_prefetch: table of per-cycle vectors after reset,
// plus hand sequences for back-pressure, asynchronous reset and counters.
module tb_ifetch_prefetch;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [63:0] haddr;
  logic        hwrite;
  logic [63:0] hwdata;
  logic [63:0] hrdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic [1:0]  dbg_state;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 hclk = ~hclk;

  ifetch_prefetch dut (
    .HCLK           (hclk),
    .HRESET         (hreset),
    .HADDR          (haddr),
    .HWRITE         (hwrite),
    .HWDATA         (hwdata),
    .HRDATA         (hrdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
`ifdef IFETCH_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // RAM model: one fixed word at 0x20000, elsewhere address-derived words.
  function automatic logic [63:0] ram_read(input logic [63:0] a);
    logic [31:0] lo, hi;
    if (a == 64'h20000) return 64'h11111111_22222222;
    lo = a[31:0] ^ 32'hDEAD0000;
    hi = (a[31:0] + 32'd4) ^ 32'hDEAD0000;
    return {hi, lo};
  endfunction

  // Expected instruction word for a byte address.
  function automatic logic [31:0] exp_data(input logic [63:0] pc);
    if (pc == 64'h20000) return 32'h22222222;
    if (pc == 64'h20004) return 32'h11111111;
    return pc[31:0] ^ 32'hDEAD0000;
  endfunction

  always_comb hrdata = ram_read(haddr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        rv;
    logic [63:0] rpc;
    logic        ev;
    logic [63:0] epc;
    logic        ef;
    logic [63:0] ehaddr;
  } vec_t;

  function automatic vec_t mk(input logic ready, input logic rv, input logic [63:0] rpc,
                              input logic ev, input logic [63:0] epc, input logic ef,
                              input logic [63:0] ehaddr);
    vec_t v;
    v.ready = ready; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ef = ef; v.ehaddr = ehaddr;
    return v;
  endfunction

  // driver tasks
  task automatic do_reset(input logic ready);
    @(negedge hclk);
    hreset         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = ready;
    repeat (2) @(negedge hclk);
    chk("rst haddr", haddr, 64'h20000);
    chk("rst hwrite", 64'(hwrite), 64'd0);
    chk("rst hwdata", hwdata, 64'd0);
    chk("rst valid", 64'(inst_valid), 64'd0);
    chk("rst data", 64'(inst_data), 64'd0);
    chk("rst pc", inst_pc, 64'd0);
    chk("rst fault", 64'(inst_fault), 64'd0);
    chk("rst state", 64'(dbg_state), 64'd0);
    hreset = 1'b1;
  endtask

  task automatic wait_valid(input string name, output logic ok);
    int n = 0;
    while (!inst_valid && n < 20) begin
      @(negedge hclk);
      n++;
    end
    ok = inst_valid;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: inst_valid timeout got 0 expected 1", name);
    end
  endtask

  vec_t vt[22];
  logic [63:0] exp_q[$];

  initial begin
    logic ok;
    logic [63:0] p;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] f0, s0;
`endif
    hreset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Per-cycle vectors starting in the BOOT cycle after reset release.
    vt[0]  = mk(1, 0, 0,         0, 0,         0, 64'h20000);
    vt[1]  = mk(1, 0, 0,         0, 0,         0, 64'h20000);
    vt[2]  = mk(1, 0, 0,         1, 64'h20000, 0, 64'h20008);
    vt[3]  = mk(0, 0, 0,         1, 64'h20004, 0, 64'h20010);
    vt[4]  = mk(0, 0, 0,         1, 64'h20004, 0, 64'h20010);
    vt[5]  = mk(1, 0, 0,         1, 64'h20004, 0, 64'h20010);
    vt[6]  = mk(1, 0, 0,         1, 64'h20008, 0, 64'h20010);
    vt[7]  = mk(1, 1, 64'h20024, 1, 64'h2000C, 0, 64'h20018);
    vt[8]  = mk(1, 0, 0,         0, 0,         0, 64'h20020);
    vt[9]  = mk(1, 0, 0,         1, 64'h20024, 0, 64'h20028);
    vt[10] = mk(1, 1, 64'h20430, 1, 64'h20028, 0, 64'h20030);
    vt[11] = mk(0, 0, 0,         0, 0,         0, 64'h20430);
    vt[12] = mk(0, 0, 0,         1, 64'h20430, 1, 64'h20430);
    vt[13] = mk(1, 0, 0,         1, 64'h20430, 1, 64'h20430);
    vt[14] = mk(1, 0, 0,         0, 0,         0, 64'h20430);
    vt[15] = mk(1, 1, 64'h20003, 0, 0,         0, 64'h20430);
    vt[16] = mk(1, 0, 0,         0, 0,         0, 64'h20000);
    vt[17] = mk(1, 1, 64'h2042C, 1, 64'h20003, 1, 64'h20000);
    vt[18] = mk(1, 0, 0,         0, 0,         0, 64'h20428);
    vt[19] = mk(1, 0, 0,         1, 64'h2042C, 0, 64'h20430);
    vt[20] = mk(1, 0, 0,         1, 64'h20430, 1, 64'h20430);
    vt[21] = mk(1, 0, 0,         0, 0,         0, 64'h20430);

    do_reset(1'b1);
    for (int i = 0; i < 22; i++) begin
      inst_ready     = vt[i].ready;
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
      #1;
      chk($sformatf("v%0d haddr", i), haddr, vt[i].ehaddr);
      chk($sformatf("v%0d valid", i), 64'(inst_valid), 64'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("v%0d pc", i), inst_pc, vt[i].epc);
        chk($sformatf("v%0d fault", i), 64'(inst_fault), 64'(vt[i].ef));
        chk($sformatf("v%0d data", i), 64'(inst_data),
            vt[i].ef ? 64'd0 : 64'(exp_data(vt[i].epc)));
      end
      @(negedge hclk);
    end
    redirect_valid = 1'b0;

    // Back-pressure from reset: two fetches fill the FIFO, then HADDR holds.
    do_reset(1'b0);
    repeat (6) @(negedge hclk);
    chk("bp haddr", haddr, 64'h20010);
    chk("bp valid", 64'(inst_valid), 64'd1);
    chk("bp head", inst_pc, 64'h20000);
    chk("bp state", 64'(dbg_state), 64'd1);
`ifdef IFETCH_PERF_CNT_EN
    f0 = perf_fetch_cnt;
    s0 = perf_stall_cnt;
    chk("perf fetches", 64'(f0), 64'd2);
    repeat (10) @(negedge hclk);
    chk("perf stall delta", 64'(perf_stall_cnt - s0), 64'd10);
    chk("perf fetch delta", 64'(perf_fetch_cnt - f0), 64'd0);
`endif
    chk("bp haddr hold", haddr, 64'h20010);
    for (int i = 0; i < 10; i++) exp_q.push_back(64'h20000 + 64'(4 * i));
    inst_ready = 1'b1;
    while (exp_q.size() > 0) begin
      wait_valid("bp resume", ok);
      if (!ok) break;
      p = exp_q.pop_front();
      chk("bp order pc", inst_pc, p);
      chk("bp order data", 64'(inst_data), 64'(exp_data(p)));
      @(negedge hclk);
    end

    // Short asynchronous reset pulse with a full FIFO.
    do_reset(1'b0);
    repeat (6) @(negedge hclk);
    chk("ar full", 64'(inst_valid), 64'd1);
    @(posedge hclk);
    #2 hreset = 1'b0;
    #1;
    chk("ar valid", 64'(inst_valid), 64'd0);
    chk("ar pc", inst_pc, 64'd0);
    chk("ar haddr", haddr, 64'h20000);
    #1 hreset = 1'b1;
    inst_ready = 1'b1;
    @(negedge hclk);
    wait_valid("ar refetch", ok);
    if (ok) begin
      chk("ar first pc", inst_pc, 64'h20000);
      chk("ar first data", 64'(inst_data), 64'h22222222);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
